// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM, one clock, two R/W ports.
// Per-byte write enables, 1- or 2-cycle read latency, selectable same-port
// read-during-write, read-valid strobes and same-address collision flag.
// Optional per-byte even parity: define DUAL_PORT_RAM_PARITY_EN.

// Read return pipeline for one port: a valid shift register alongside a
// payload register chain. A stage only reloads when valid data arrives,
// so the output holds its last value between strobes.
module dual_port_ram_be_rd #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          vld
);

  logic [LAT:1]         vld_q, vld_d;
  logic [LAT:1][DW-1:0] dat_q, dat_d;
  logic [LAT:0]         vld_pipe;
  logic [LAT:0][DW-1:0] dat_pipe;

  assign vld_pipe = {vld_q, acc};
  assign dat_pipe = {dat_q, din};

  // Shift valid every cycle; payload stages load only behind a valid bit.
  always_comb begin
    vld_d = '0;
    dat_d = dat_q;
    for (int k = 1; k <= LAT; k++) begin
      vld_d[k] = vld_pipe[k-1];
      if (vld_pipe[k-1]) dat_d[k] = dat_pipe[k-1];
    end
  end

  // Reset discards in-flight reads and clears the output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign dout = dat_q[LAT];
  assign vld  = vld_q[LAT];

endmodule

module dual_port_ram_be #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  parameter  int RD_LATENCY = 1,
  parameter  int RDW_MODE   = 0,
  localparam int AW         = $clog2(DEPTH),
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NB-1:0]         a_be,
  input  logic [AW-1:0]         a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [NB-1:0]         b_be,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
`ifdef DUAL_PORT_RAM_PARITY_EN
  output logic [NB-1:0]         a_perr,
  output logic [NB-1:0]         b_perr,
`endif
  output logic                  collision
);

`ifdef DUAL_PORT_RAM_PARITY_EN
  localparam int PW = DATA_WIDTH + NB;
`else
  localparam int PW = DATA_WIDTH;
`endif

  // Port 0 = A, port 1 = B.
  logic [1:0]                 en, we, wr, rng, rvld;
  logic [1:0][NB-1:0]         be;
  logic [1:0][AW-1:0]         addr;
  logic [1:0][DATA_WIDTH-1:0] wdata, rd_word;
  logic [1:0][PW-1:0]         pay, pout;
  logic                       same;
  logic                       coll_d, coll_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign en    = {b_en,    a_en};
  assign we    = {b_we,    a_we};
  assign be    = {b_be,    a_be};
  assign addr  = {b_addr,  a_addr};
  assign wdata = {b_wdata, a_wdata};
  assign same  = (a_addr == b_addr);

  // Address range check (only bites when DEPTH is not a power of two) and
  // effective write qualification per port.
  always_comb begin
    rng = '0;
    wr  = '0;
    for (int p = 0; p < 2; p++) begin
      rng[p] = (32'(addr[p]) < 32'(DEPTH));
      wr[p]  = en[p] & we[p] & rng[p];
    end
  end

  // Byte-wise array update; on a same-address dual write A owns the
  // bytes it enables and B only fills bytes A leaves alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr[0] && be[0][i])
        mem[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
      if (wr[1] && be[1][i] && !(wr[0] && be[0][i] && same))
        mem[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
    end
  end

  // Read word per port: pre-write contents, optionally overlaid with this
  // port's own enabled write bytes. The other port's write is never visible.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = rng[p] ? mem[addr[p]] : '0;
      if (RDW_MODE == 1) begin
        for (int i = 0; i < NB; i++)
          if (wr[p] && be[p][i]) rd_word[p][8*i +: 8] = wdata[p][8*i +: 8];
      end
    end
  end

`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [NB-1:0]      par [DEPTH];
  logic [1:0][NB-1:0] rd_par, perr_c;

  // Parity array follows the data array byte for byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr[0] && be[0][i])
        par[addr[0]][i] <= ^wdata[0][8*i +: 8];
      if (wr[1] && be[1][i] && !(wr[0] && be[0][i] && same))
        par[addr[1]][i] <= ^wdata[1][8*i +: 8];
    end
  end

  // Stored parity (with the same read-during-write overlay) against read bytes.
  always_comb begin
    rd_par = '0;
    perr_c = '0;
    for (int p = 0; p < 2; p++) begin
      rd_par[p] = rng[p] ? par[addr[p]] : '0;
      for (int i = 0; i < NB; i++) begin
        if (RDW_MODE == 1 && wr[p] && be[p][i]) rd_par[p][i] = ^wdata[p][8*i +: 8];
        perr_c[p][i] = rd_par[p][i] ^ (^rd_word[p][8*i +: 8]);
      end
      pay[p] = {perr_c[p], rd_word[p]};
    end
  end

  assign a_perr = rvld[0] ? pout[0][PW-1:DATA_WIDTH] : '0;
  assign b_perr = rvld[1] ? pout[1][PW-1:DATA_WIDTH] : '0;
`else
  assign pay = rd_word;
`endif

  // One return pipeline per port.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    dual_port_ram_be_rd #(.DW(PW), .LAT(RD_LATENCY)) u_rd (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (en[p]),
      .din   (pay[p]),
      .dout  (pout[p]),
      .vld   (rvld[p])
    );
  end

  assign a_rdata  = pout[0][DATA_WIDTH-1:0];
  assign b_rdata  = pout[1][DATA_WIDTH-1:0];
  assign a_rvalid = rvld[0];
  assign b_rvalid = rvld[1];

  // Same-address conflict: both ports active and at least one really writes.
  always_comb begin
    coll_d = en[0] & en[1] & same & ((we[0] & (|be[0])) | (we[1] & (|be[1])));
  end

  // Registered collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign collision = coll_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be. Two instances share one stimulus stream:
// d1 = defaults (latency 1, read-first, DEPTH 256), d2 = latency 2,
// write-first, DEPTH 12 (non power of two, so addr 13 is out of range).
// Parity checks compile in when DUAL_PORT_RAM_PARITY_EN is defined.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wd, b_wd;

  logic [31:0] d1_ard, d1_brd, d2_ard, d2_brd;
  logic        d1_av, d1_bv, d2_av, d2_bv, d1_col, d2_col;
`ifdef DUAL_PORT_RAM_PARITY_EN
  logic [3:0]  d1_ape, d1_bpe, d2_ape, d2_bpe;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_be d1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wd),
    .a_rdata(d1_ard), .a_rvalid(d1_av),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wd),
    .b_rdata(d1_brd), .b_rvalid(d1_bv),
`ifdef DUAL_PORT_RAM_PARITY_EN
    .a_perr(d1_ape), .b_perr(d1_bpe),
`endif
    .collision(d1_col)
  );

  dual_port_ram_be #(.DEPTH(12), .RD_LATENCY(2), .RDW_MODE(1)) d2 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr[3:0]), .a_wdata(a_wd),
    .a_rdata(d2_ard), .a_rvalid(d2_av),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr[3:0]), .b_wdata(b_wd),
    .b_rdata(d2_brd), .b_rvalid(d2_bv),
`ifdef DUAL_PORT_RAM_PARITY_EN
    .a_perr(d2_ape), .b_perr(d2_bpe),
`endif
    .collision(d2_col)
  );

  typedef struct {
    logic        ae, aw; logic [3:0] abe; logic [7:0] aad; logic [31:0] awd;
    logic        be, bw; logic [3:0] bbe; logic [7:0] bad; logic [31:0] bwd;
    logic        av, ac; logic [31:0] a1, a2;   // a1: d1 data, a2: d2 data
    logic        bv, bc; logic [31:0] b1, b2;
    logic        col;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic ae, aw, input logic [3:0] abe, input logic [7:0] aad, input logic [31:0] awd,
    input logic be, bw, input logic [3:0] bbe, input logic [7:0] bad, input logic [31:0] bwd,
    input logic av, ac, input logic [31:0] a1, a2,
    input logic bv, bc, input logic [31:0] b1, b2, input logic col);
    vec_t v;
    v.ae = ae; v.aw = aw; v.abe = abe; v.aad = aad; v.awd = awd;
    v.be = be; v.bw = bw; v.bbe = bbe; v.bad = bad; v.bwd = bwd;
    v.av = av; v.ac = ac; v.a1 = a1; v.a2 = a2;
    v.bv = bv; v.bc = bc; v.b1 = b1; v.b2 = b2; v.col = col;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_wd = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_wd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current memory image as seen by each instance for the streaming reads.
  function automatic logic [31:0] e1(input logic [7:0] ad);
    case (ad)
      8'd5:    return 32'hDE22BE44;
      8'd7:    return 32'h55555555;
      8'd9:    return 32'h000000AA;
      default: return 32'hCAFEF00D;
    endcase
  endfunction

  function automatic logic [31:0] e2(input logic [7:0] ad);
    return (ad == 8'd13) ? 32'h0 : e1(ad);
  endfunction

  initial begin
    logic [7:0] sa [8];
    //        ae aw abe aad  awd            be bw bbe bad  bwd           av ac a1            a2            bv bc b1            b2            col
    tbl[0]  = mk(1, 1, 4'hF, 5,  32'hDEADBEEF, 1, 1, 4'hF, 7, 32'hAAAAAAAA, 1, 0, 0,            0,            1, 0, 0,            0,            0);
    tbl[1]  = mk(1, 1, 4'hF, 9,  32'h00000000, 0, 0, 4'h0, 0, 32'h0,        1, 0, 0,            0,            0, 0, 0,            0,            0);
    tbl[2]  = mk(1, 0, 4'h0, 5,  32'h0,        0, 0, 4'h0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,            0,            0);
    tbl[3]  = mk(0, 0, 4'h0, 0,  32'h0,        1, 1, 4'h5, 5, 32'h11223344, 0, 0, 0,            0,            1, 1, 32'hDEADBEEF, 32'hDE22BE44, 0);
    tbl[4]  = mk(0, 0, 4'h0, 0,  32'h0,        1, 0, 4'h0, 5, 32'h0,        0, 0, 0,            0,            1, 1, 32'hDE22BE44, 32'hDE22BE44, 0);
    tbl[5]  = mk(1, 1, 4'hF, 7,  32'h55555555, 1, 0, 4'h0, 7, 32'h0,        1, 1, 32'hAAAAAAAA, 32'h55555555, 1, 1, 32'hAAAAAAAA, 32'hAAAAAAAA, 1);
    tbl[6]  = mk(1, 1, 4'h3, 9,  32'h000000AA, 1, 1, 4'h6, 9, 32'h0000BB00, 1, 1, 32'h0,        32'h000000AA, 1, 1, 32'h0,        32'h0000BB00, 1);
    tbl[7]  = mk(1, 0, 4'h0, 9,  32'h0,        1, 0, 4'h0, 9, 32'h0,        1, 1, 32'h000000AA, 32'h000000AA, 1, 1, 32'h000000AA, 32'h000000AA, 0);
    tbl[8]  = mk(1, 1, 4'h0, 9,  32'hFFFFFFFF, 1, 0, 4'h0, 9, 32'h0,        1, 1, 32'h000000AA, 32'h000000AA, 1, 1, 32'h000000AA, 32'h000000AA, 0);
    tbl[9]  = mk(1, 1, 4'hF, 13, 32'hCAFEF00D, 0, 0, 4'h0, 0, 32'h0,        1, 0, 0,            0,            0, 0, 0,            0,            0);
    tbl[10] = mk(1, 0, 4'h0, 13, 32'h0,        1, 0, 4'h0, 7, 32'h0,        1, 1, 32'hCAFEF00D, 32'h0,        1, 1, 32'h55555555, 32'h55555555, 0);
    tbl[11] = mk(0, 0, 4'h0, 0,  32'h0,        0, 0, 4'h0, 0, 32'h0,        0, 0, 0,            0,            0, 0, 0,            0,            0);

    // Reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d1_ard", d1_ard, 0); chk("rst_d1_brd", d1_brd, 0);
    chk("rst_d1_av",  d1_av,  0); chk("rst_d1_bv",  d1_bv,  0);
    chk("rst_d1_col", d1_col, 0);
    chk("rst_d2_ard", d2_ard, 0); chk("rst_d2_brd", d2_brd, 0);
    chk("rst_d2_av",  d2_av,  0); chk("rst_d2_bv",  d2_bv,  0);
    chk("rst_d2_col", d2_col, 0);
    rst_n = 1'b1;

    // Vector table: d1 answers after one edge, d2 one edge later.
    for (int k = 0; k < NV; k++) begin
      a_en = tbl[k].ae; a_we = tbl[k].aw; a_be = tbl[k].abe; a_addr = tbl[k].aad; a_wd = tbl[k].awd;
      b_en = tbl[k].be; b_we = tbl[k].bw; b_be = tbl[k].bbe; b_addr = tbl[k].bad; b_wd = tbl[k].bwd;
      step();
      chk($sformatf("v%0d_d1_av", k), d1_av, tbl[k].av);
      chk($sformatf("v%0d_d1_bv", k), d1_bv, tbl[k].bv);
      if (tbl[k].av && tbl[k].ac) chk($sformatf("v%0d_d1_ard", k), d1_ard, tbl[k].a1);
      if (tbl[k].bv && tbl[k].bc) chk($sformatf("v%0d_d1_brd", k), d1_brd, tbl[k].b1);
      chk($sformatf("v%0d_d1_col", k), d1_col, tbl[k].col);
      chk($sformatf("v%0d_d2_col", k), d2_col, tbl[k].col);
      if (k > 0) begin
        chk($sformatf("v%0d_d2_av", k-1), d2_av, tbl[k-1].av);
        chk($sformatf("v%0d_d2_bv", k-1), d2_bv, tbl[k-1].bv);
        if (tbl[k-1].av && tbl[k-1].ac) chk($sformatf("v%0d_d2_ard", k-1), d2_ard, tbl[k-1].a2);
        if (tbl[k-1].bv && tbl[k-1].bc) chk($sformatf("v%0d_d2_brd", k-1), d2_brd, tbl[k-1].b2);
      end
    end

    // rdata holds once the strobes are gone
    idle();
    step();
    chk("hold_d1_av", d1_av, 0);           chk("hold_d2_av", d2_av, 0);
    chk("hold_d1_ard", d1_ard, 32'hCAFEF00D);
    chk("hold_d1_brd", d1_brd, 32'h55555555);
    chk("hold_d2_brd", d2_brd, 32'h55555555);

    // Streaming: 8 back-to-back reads on A
    sa[0] = 5; sa[1] = 7; sa[2] = 9; sa[3] = 5; sa[4] = 7; sa[5] = 9; sa[6] = 13; sa[7] = 5;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i < 8) begin a_en = 1; a_addr = sa[i]; end
      step();
      if (i < 8) begin
        chk($sformatf("st%0d_d1_av", i), d1_av, 1);
        chk($sformatf("st%0d_d1_ard", i), d1_ard, e1(sa[i]));
      end else chk($sformatf("st%0d_d1_av", i), d1_av, 0);
      if (i >= 1 && i <= 8) begin
        chk($sformatf("st%0d_d2_av", i), d2_av, 1);
        chk($sformatf("st%0d_d2_ard", i), d2_ard, e2(sa[i-1]));
      end else chk($sformatf("st%0d_d2_av", i), d2_av, 0);
    end

    // Reset in the middle of a read stream
    for (int i = 0; i < 4; i++) begin
      idle(); a_en = 1; a_addr = sa[i];
      step();
    end
    chk("mr_d2_av_pre", d2_av, 1);
    chk("mr_d2_ard_pre", d2_ard, 32'h000000AA);
    rst_n = 1'b0;
    idle();
    #1;
    chk("mr_d2_av_rst", d2_av, 0);
    chk("mr_d2_ard_rst", d2_ard, 0);
    chk("mr_d1_av_rst", d1_av, 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr_post%0d_d1_av", i), d1_av, 0);
      chk($sformatf("mr_post%0d_d2_av", i), d2_av, 0);
    end
    a_en = 1; a_addr = 9;
    step();
    chk("mr_keep_d1_av", d1_av, 1);
    chk("mr_keep_d1_ard", d1_ard, 32'h000000AA);
    idle();
    step();
    chk("mr_keep_d2_av", d2_av, 1);
    chk("mr_keep_d2_ard", d2_ard, 32'h000000AA);

`ifdef DUAL_PORT_RAM_PARITY_EN
    // Corrupt one stored bit of byte 2 and read it back
    idle(); a_en = 1; a_we = 1; a_be = 4'hF; a_addr = 3; a_wd = 32'h12345678;
    step();
    idle();
    step();
    d1.mem[3][16] = ~d1.mem[3][16];
    a_en = 1; a_addr = 3;
    step();
    chk("par_d1_av", d1_av, 1);
    chk("par_d1_ape", {28'h0, d1_ape}, 32'h4);
    idle();
    step();
    chk("par_d1_ape_idle", {28'h0, d1_ape}, 32'h0);
    chk("par_d2_ape", {28'h0, d2_ape}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
